// File: rtl/address_block.sv
// Operation generator feeding transmitter_block: turns a CSR-programmed test into a stream of
// read/write op packets with fixed, running or pseudo-random addresses, then reports done/abort.
module address_block #(
  parameter ADDR_TYPE      = "BYTE",
  parameter int AMM_ADDR_W  = 31,
  parameter int DATA_B_W    = 16,
  parameter int ADDR_B_W    = 4,
  parameter int AMM_BURST_W = 11,
  localparam int PKT_W      = 1 + AMM_ADDR_W + 3 * ADDR_B_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_test_i,
  input  logic [3:0][31:0] test_param_reg_i,
  input  logic             cmd_accept_ready_i,
  input  logic             trans_block_busy_i,
  input  logic             error_check_i,
  output logic             op_valid_o,
  output logic [PKT_W-1:0] op_pkt_o,
  output logic             addr_block_busy_o,
  output logic             test_done_o,
  output logic             test_abort_o
);

  localparam bit WORD_MODE = (ADDR_TYPE == "WORD");
  localparam int BURST_W   = AMM_BURST_W - 1;

  localparam logic [1:0] TM_READ = 2'd0;
  localparam logic [1:0] TM_WAC  = 2'd2;
  localparam logic [1:0] TM_RSVD = 2'd3;
  localparam logic [1:0] AM_RUN  = 2'd1;
  localparam logic [1:0] AM_RND  = 2'd2;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, DRAIN, DONE, ABORT} state_t;

  state_t               state, state_nxt;
  logic [31:0]          cnt, cnt_inc, n_ops;
  logic                 phase;
  logic [31:0]          lfsr, lfsr_nxt, addr, addr_nxt, seed, step;
  logic [BURST_W-1:0]   burst;
  logic [1:0]           test_mode, addr_mode;
  logic                 xfer, last_op, first_type;
  logic                 unused_ok;

  // Galois form of x^32+x^22+x^2+x+1, shifting toward bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [PKT_W-1:0] build_pkt(input logic [31:0] a,
                                                 input logic [BURST_W-1:0] b,
                                                 input logic pkt_type);
    logic [AMM_ADDR_W-1:0] wa;
    logic [ADDR_B_W-1:0]   so, eo;
    logic [ADDR_B_W:0]     lbb;
    if (WORD_MODE) begin
      wa  = AMM_ADDR_W'(a);
      so  = '0;
      eo  = '0;
      lbb = '0;
    end else begin
      wa  = AMM_ADDR_W'(a >> ADDR_B_W);
      so  = a[ADDR_B_W-1:0];
      eo  = ADDR_B_W'(a + 32'(b));
      lbb = {1'b0, so} + {1'b0, b[ADDR_B_W-1:0]};
    end
    return {pkt_type, wa, so, eo, lbb};
  endfunction

  assign unused_ok = &{1'b0, test_param_reg_i[2], test_param_reg_i[1]};

  assign cnt_inc    = cnt + 32'd1;
  assign last_op    = (test_mode != TM_WAC) || phase;
  assign first_type = (test_mode == TM_READ);
  assign seed       = (test_param_reg_i[3] == 32'd0) ? 32'hFFFF_FFFF : test_param_reg_i[3];
  assign step       = WORD_MODE ? (32'(burst) + 32'd1) * 32'(DATA_B_W) : 32'(burst) + 32'd1;
  assign lfsr_nxt   = lfsr_step(lfsr);

  always_comb begin
    addr_nxt = addr;
    case (addr_mode)
      AM_RUN:  addr_nxt = addr + step;
      AM_RND:  addr_nxt = lfsr_nxt;
      default: addr_nxt = addr;
    endcase
  end

  always_comb begin
    state_nxt = state;
    xfer      = (state == SEND) && cmd_accept_ready_i;
    case (state)
      IDLE: begin
        if (start_test_i) begin
          if (test_param_reg_i[0] == 32'd0 || test_param_reg_i[1][17:16] == TM_RSVD)
            state_nxt = DRAIN;
          else
            state_nxt = LOAD;
        end
      end
      LOAD:  state_nxt = SEND;
      SEND:  if (xfer && last_op && cnt_inc == n_ops) state_nxt = DRAIN;
      DRAIN: if (!trans_block_busy_i && cmd_accept_ready_i) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      ABORT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A compare error pre-empts anything else in flight, including a same-cycle transfer.
    if (error_check_i && (state == LOAD || state == SEND || state == DRAIN))
      state_nxt = ABORT;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      phase    <= 1'b0;
      lfsr     <= 32'hFFFF_FFFF;
      op_pkt_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_test_i) begin
            cnt   <= '0;
            phase <= 1'b0;
            lfsr  <= seed;
          end
        end
        LOAD: op_pkt_o <= build_pkt(addr, burst, first_type);
        SEND: begin
          if (xfer && !error_check_i) begin
            if (!last_op) begin
              phase    <= 1'b1;
              op_pkt_o <= build_pkt(addr, burst, 1'b1);
            end else begin
              cnt      <= cnt_inc;
              phase    <= 1'b0;
              if (addr_mode == AM_RND) lfsr <= lfsr_nxt;
              op_pkt_o <= build_pkt(addr_nxt, burst, first_type);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Test parameters are captured once at start so CSR writes mid-test are harmless.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && start_test_i) begin
      n_ops     <= test_param_reg_i[0];
      burst     <= test_param_reg_i[1][BURST_W-1:0];
      test_mode <= test_param_reg_i[1][17:16];
      addr_mode <= test_param_reg_i[1][21:20];
      addr      <= (test_param_reg_i[1][21:20] == AM_RND) ? seed : test_param_reg_i[3];
    end else if (state == SEND && xfer && !error_check_i && last_op) begin
      addr <= addr_nxt;
    end
  end

  assign op_valid_o        = (state == SEND);
  assign addr_block_busy_o = (state != IDLE);
  assign test_done_o       = (state == DONE);
  assign test_abort_o      = (state == ABORT);

endmodule

// File: tb/tb_address_block.sv
// Randomised bench for address_block: an op-list model built from the test parameters is
// compared against every transferred packet, plus directed abort/reset/latency scenarios.
module tb_address_block;

  localparam int PKT_W = 45;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_test_i = 1'b0;
  logic [3:0][31:0] test_param_reg_i = '0;
  logic             cmd_accept_ready_i = 1'b0;
  logic             trans_block_busy_i = 1'b0;
  logic             error_check_i = 1'b0;
  logic             op_valid_o;
  logic [PKT_W-1:0] op_pkt_o;
  logic             addr_block_busy_o;
  logic             test_done_o;
  logic             test_abort_o;

  int checks = 0;
  int failures = 0;
  logic [PKT_W-1:0] exp_q[$];

  address_block dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .start_test_i       (start_test_i),
    .test_param_reg_i   (test_param_reg_i),
    .cmd_accept_ready_i (cmd_accept_ready_i),
    .trans_block_busy_i (trans_block_busy_i),
    .error_check_i      (error_check_i),
    .op_valid_o         (op_valid_o),
    .op_pkt_o           (op_pkt_o),
    .addr_block_busy_o  (addr_block_busy_o),
    .test_done_o        (test_done_o),
    .test_abort_o       (test_abort_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected packet from the address-to-burst rules for BYTE granularity.
  function automatic logic [PKT_W-1:0] mdl_pkt(input logic [31:0] a, input int burst, input bit rd);
    logic [31:0] wa, last_byte;
    int so, eo, lbb;
    wa        = a / 16;
    so        = int'(a % 16);
    last_byte = a + 32'(burst);
    eo        = int'(last_byte % 16);
    lbb       = so + (burst % 16);
    return {rd, wa[30:0], 4'(so), 4'(eo), 5'(lbb)};
  endfunction

  function automatic logic [31:0] mdl_lfsr(input logic [31:0] s);
    logic [31:0] taps;
    logic        out_bit;
    taps    = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
    out_bit = s[0];
    s       = s >> 1;
    return out_bit ? (s ^ taps) : s;
  endfunction

  task automatic build_expected(input int n, input int tm, input int am, input int burst,
                                input logic [31:0] base);
    logic [31:0] a;
    exp_q.delete();
    if (tm == 3) return;
    a = (am == 2 && base == 0) ? 32'hFFFF_FFFF : base;
    for (int i = 0; i < n; i++) begin
      if (tm == 0) exp_q.push_back(mdl_pkt(a, burst, 1'b1));
      if (tm == 1) exp_q.push_back(mdl_pkt(a, burst, 1'b0));
      if (tm == 2) begin
        exp_q.push_back(mdl_pkt(a, burst, 1'b0));
        exp_q.push_back(mdl_pkt(a, burst, 1'b1));
      end
      if (am == 1) a = a + 32'(burst) + 32'd1;
      else if (am == 2) a = mdl_lfsr(a);
    end
  endtask

  task automatic set_params(input int n, input int tm, input int am, input int burst,
                            input logic [31:0] base);
    test_param_reg_i[0] = 32'(n);
    test_param_reg_i[1] = 32'(burst & 1023) | (32'(tm) << 16) | (32'(am) << 20);
    test_param_reg_i[2] = $urandom;
    test_param_reg_i[3] = base;
  endtask

  task automatic run_test(input int n, input int tm, input int am, input int burst,
                          input logic [31:0] base, input int ready_pct, input int busy_pct);
    int cyc;
    bit done_seen, prev_hold, has_ops;
    logic [PKT_W-1:0] prev_pkt;
    build_expected(n, tm, am, burst, base);
    has_ops = (exp_q.size() > 0);
    @(negedge clk);
    set_params(n, tm, am, burst, base);
    start_test_i = 1'b1;
    @(negedge clk);
    start_test_i = 1'b0;
    check_eq("busy_after_start", addr_block_busy_o, 1);
    check_eq("valid_latency_t1", op_valid_o, 0);
    cyc = 0; done_seen = 0; prev_hold = 0; prev_pkt = '0;
    while (!done_seen && cyc < 3000) begin
      cmd_accept_ready_i = ($urandom_range(99) < ready_pct);
      trans_block_busy_i = ($urandom_range(99) < busy_pct);
      if (cyc == 1 && has_ops) check_eq("valid_latency_t2", op_valid_o, 1);
      if (cyc == 3) begin
        set_params($urandom_range(9), $urandom_range(3), $urandom_range(3), $urandom_range(1023), $urandom);
        start_test_i = 1'b1;
      end else begin
        start_test_i = 1'b0;
      end
      if (prev_hold) begin
        check_eq("hold_valid", op_valid_o, 1);
        check_eq("hold_pkt", op_pkt_o, prev_pkt);
      end
      if (op_valid_o && cmd_accept_ready_i) begin
        if (exp_q.size() == 0) check_eq("extra_op", op_pkt_o, 0);
        else check_eq("op_pkt", op_pkt_o, exp_q.pop_front());
      end
      if (test_abort_o) check_eq("unexpected_abort", test_abort_o, 0);
      prev_hold = op_valid_o && !cmd_accept_ready_i;
      prev_pkt  = op_pkt_o;
      if (test_done_o) begin
        done_seen = 1;
        check_eq("ops_left_at_done", exp_q.size(), 0);
        check_eq("valid_at_done", op_valid_o, 0);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    start_test_i = 1'b0;
    check_eq("done_seen", done_seen, 1);
    @(negedge clk);
    check_eq("done_one_cycle", test_done_o, 0);
    check_eq("idle_after_done", addr_block_busy_o, 0);
  endtask

  task automatic wait_valid(output bit seen);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = op_valid_o;
    end
    check_eq("valid_seen", seen, 1);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", op_valid_o, 0);
    check_eq("rst_pkt", op_pkt_o, 0);
    check_eq("rst_busy", addr_block_busy_o, 0);
    check_eq("rst_done", test_done_o, 0);
    check_eq("rst_abort", test_abort_o, 0);
    rst_i = 1'b0;
    @(negedge clk);

    // Directed scenarios, then randomised ones.
    run_test(3, 1, 0, 0, 32'h100, 100, 0);
    check_eq("model_fix_word", mdl_pkt(32'h100, 0, 1'b0), {1'b0, 31'h10, 4'd0, 4'd0, 5'd0});
    run_test(2, 2, 1, 3, 32'h0E, 100, 0);
    check_eq("model_wac_first", mdl_pkt(32'h0E, 3, 1'b0), {1'b0, 31'h0, 4'd14, 4'd1, 5'd17});
    run_test(4, 2, 1, 3, 32'h0E, 50, 20);
    run_test(4, 0, 2, 7, 32'h0, 60, 10);
    run_test(3, 1, 1, 15, 32'hFFFF_FFF8, 100, 0);
    run_test(0, 1, 0, 0, 32'h40, 100, 30);
    run_test(5, 3, 1, 2, 32'h80, 100, 0);
    for (int t = 0; t < 10; t++)
      run_test($urandom_range(6), $urandom_range(3), $urandom_range(3), $urandom_range(1023),
               $urandom, $urandom_range(100, 30), $urandom_range(50));

    // Error while transferring: abort pulse, no done.
    cmd_accept_ready_i = 1'b1;
    trans_block_busy_i = 1'b0;
    set_params(6, 1, 1, 1, 32'h200);
    start_test_i = 1'b1;
    @(negedge clk);
    start_test_i = 1'b0;
    wait_valid(seen);
    @(negedge clk);
    error_check_i = 1'b1;
    @(negedge clk);
    error_check_i = 1'b0;
    check_eq("abort_valid", op_valid_o, 0);
    check_eq("abort_pulse", test_abort_o, 1);
    check_eq("abort_no_done", test_done_o, 0);
    @(negedge clk);
    check_eq("abort_one_cycle", test_abort_o, 0);
    check_eq("abort_idle", addr_block_busy_o, 0);
    check_eq("abort_done_low", test_done_o, 0);

    // Error while idle is ignored.
    error_check_i = 1'b1;
    @(negedge clk);
    error_check_i = 1'b0;
    check_eq("idle_err_abort", test_abort_o, 0);
    check_eq("idle_err_busy", addr_block_busy_o, 0);

    // Reset in the middle of a test.
    set_params(8, 2, 1, 5, 32'h300);
    start_test_i = 1'b1;
    @(negedge clk);
    start_test_i = 1'b0;
    wait_valid(seen);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_eq("midrst_valid", op_valid_o, 0);
    check_eq("midrst_pkt", op_pkt_o, 0);
    check_eq("midrst_busy", addr_block_busy_o, 0);
    check_eq("midrst_done", test_done_o, 0);
    check_eq("midrst_abort", test_abort_o, 0);
    @(negedge clk);

    run_test(3, 2, 2, 9, 32'h1234_5678, 70, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
